// File: rtl/snake_streamer_if.sv
// snake_streamer_if: segment stream from the snake body owner to the VGA renderer.
//   snake_x / snake_y : tile of the segment being streamed
//   snake_dir         : heading from this segment toward the next, tail-ward one
//   snake_first       : segment is the head
//   snake_last        : segment is the tail
//   snake_valid       : stream fields are valid this cycle
// Modports: master = producer (snake_streamer), slave = consumer (renderer).
interface snake_streamer_if;
    logic [4:0] snake_x;
    logic [3:0] snake_y;
    logic [1:0] snake_dir;
    logic       snake_first;
    logic       snake_last;
    logic       snake_valid;

    modport master (
        output snake_x, snake_y, snake_dir, snake_first, snake_last, snake_valid
    );

    modport slave (
        input snake_x, snake_y, snake_dir, snake_first, snake_last, snake_valid
    );
endinterface

// File: rtl/snake_streamer.sv
// snake_streamer: owns the snake body (head tile, direction queue, length),
// applies move/grow steps, detects wall and self collisions, and streams the
// body head to tail, one segment per clock, followed by one idle gap cycle.
//
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   step, grow, dir_in         move request, grow-on-move, requested heading
//                              (0 up, 1 down, 2 left, 3 right)
//   snake_head_x/_y            current head tile
//   failure, success           sticky game-over flags
//   bus                        segment stream (snake_streamer_if.master)
//
// Build option: define SNAKE_WRAP_EN to make the playfield wrap at its edges
// instead of treating them as walls.
//
// state  | meaning
// S_WALK | a body segment is on the stream; idx is its position
// S_GAP  | stream idle for one cycle; pending move is applied on leaving
module snake_streamer #(
    parameter int GAME_WIDTH  = 18,
    parameter int GAME_HEIGHT = 13,
    parameter int MAX_LEN     = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       step,
    input  logic       grow,
    input  logic [1:0] dir_in,
    output logic [4:0] snake_head_x,
    output logic [3:0] snake_head_y,
    output logic       failure,
    output logic       success,
    snake_streamer_if.master bus
);
    localparam int LW = $clog2(MAX_LEN + 1);
    localparam int IW = $clog2(MAX_LEN);
    localparam logic signed [5:0] XMAX = 6'(GAME_WIDTH);
    localparam logic signed [4:0] YMAX = 5'(GAME_HEIGHT);

    typedef enum logic {S_WALK, S_GAP} state_t;

    state_t         state, state_n;
    logic [LW-1:0]  idx, idx_n, len, len_n, nidx;
    logic [1:0]     dirs [MAX_LEN];
    logic [1:0]     dirs_n [MAX_LEN];
    logic [1:0]     heading, heading_n, d_sel;
    logic [4:0]     hx, hx_n, wx, wx_n, sx, sx_n;
    logic [3:0]     hy, hy_n, wy, wy_n, sy, sy_n;
    logic [1:0]     sdir, sdir_n;
    logic           sfirst, sfirst_n, slast, slast_n, svalid, svalid_n;
    logic           pending, pending_n, pend_grow, pend_grow_n;
    logic           failure_n, success_n, wall_hit;
    logic signed [5:0] nx;
    logic signed [4:0] ny;

    function automatic logic [1:0] opp(input logic [1:0] d);
        return {d[1], ~d[0]};
    endfunction

    function automatic logic signed [5:0] dx_of(input logic [1:0] d);
        case (d)
            2'd2:    return -6'sd1;
            2'd3:    return 6'sd1;
            default: return 6'sd0;
        endcase
    endfunction

    function automatic logic signed [4:0] dy_of(input logic [1:0] d);
        case (d)
            2'd0:    return -5'sd1;
            2'd1:    return 5'sd1;
            default: return 5'sd0;
        endcase
    endfunction

    // Edge wrapping is harmless without SNAKE_WRAP_EN: out-of-range tiles are
    // then only ever produced past the tail and are never streamed.
    function automatic logic [4:0] fix_x(input logic signed [5:0] v);
        if (v < 6'sd1)     return 5'(GAME_WIDTH);
        else if (v > XMAX) return 5'd1;
        else               return v[4:0];
    endfunction

    function automatic logic [3:0] fix_y(input logic signed [4:0] v);
        if (v < 5'sd1)     return 4'(GAME_HEIGHT);
        else if (v > YMAX) return 4'd1;
        else               return v[3:0];
    endfunction

    always_comb begin
        state_n     = state;
        idx_n       = idx;
        len_n       = len;
        dirs_n      = dirs;
        heading_n   = heading;
        hx_n        = hx;
        hy_n        = hy;
        wx_n        = wx;
        wy_n        = wy;
        pending_n   = pending | step;
        pend_grow_n = pend_grow | (step & grow);
        failure_n   = failure;
        success_n   = success;
        sx_n        = '0;
        sy_n        = '0;
        sdir_n      = '0;
        sfirst_n    = 1'b0;
        slast_n     = 1'b0;
        svalid_n    = 1'b0;
        nidx        = idx + 1'b1;

        // A direct reversal would fold the head into its neck; keep going.
        d_sel = (dir_in == opp(heading)) ? heading : dir_in;
        nx    = $signed({1'b0, hx}) + dx_of(d_sel);
        ny    = $signed({1'b0, hy}) + dy_of(d_sel);
`ifdef SNAKE_WRAP_EN
        wall_hit = 1'b0;
`else
        wall_hit = (nx < 6'sd1) || (nx > XMAX) || (ny < 5'sd1) || (ny > YMAX);
`endif

        // Registered segment already on the stream overlapping the head.
        if (svalid && !sfirst && sx == hx && sy == hy)
            failure_n = 1'b1;

        case (state)
            S_WALK: begin
                if (idx == len - 1'b1) begin
                    state_n = S_GAP;
                end else begin
                    idx_n    = nidx;
                    sx_n     = wx;
                    sy_n     = wy;
                    svalid_n = 1'b1;
                    slast_n  = (nidx == len - 1'b1);
                    sdir_n   = slast_n ? 2'd0 : dirs[nidx[IW-1:0]];
                    wx_n     = fix_x($signed({1'b0, wx}) + dx_of(dirs[nidx[IW-1:0]]));
                    wy_n     = fix_y($signed({1'b0, wy}) + dy_of(dirs[nidx[IW-1:0]]));
                end
            end
            S_GAP: begin
                pending_n   = 1'b0;
                pend_grow_n = 1'b0;
                if ((pending | step) && !failure && !success) begin
                    if (wall_hit) begin
                        failure_n = 1'b1;
                    end else begin
                        hx_n      = fix_x(nx);
                        hy_n      = fix_y(ny);
                        heading_n = d_sel;
                        for (int k = MAX_LEN - 1; k > 0; k--)
                            dirs_n[k] = dirs[k-1];
                        dirs_n[0] = opp(d_sel);
                        if ((pend_grow | (step & grow)) && len != LW'(MAX_LEN))
                            len_n = len + 1'b1;
                        if (len_n == LW'(MAX_LEN))
                            success_n = 1'b1;
                    end
                end
                // Leaving the gap emits the (possibly moved) head right away.
                state_n  = S_WALK;
                idx_n    = '0;
                sx_n     = hx_n;
                sy_n     = hy_n;
                sdir_n   = dirs_n[0];
                sfirst_n = 1'b1;
                svalid_n = 1'b1;
                wx_n     = fix_x($signed({1'b0, hx_n}) + dx_of(dirs_n[0]));
                wy_n     = fix_y($signed({1'b0, hy_n}) + dy_of(dirs_n[0]));
            end
            default: state_n = S_GAP;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_GAP;
            idx       <= '0;
            len       <= LW'(2);
            for (int k = 0; k < MAX_LEN; k++)
                dirs[k] <= (k == 0) ? 2'd2 : 2'd0;
            heading   <= 2'd3;
            hx        <= 5'd3;
            hy        <= 4'd7;
            wx        <= '0;
            wy        <= '0;
            pending   <= 1'b0;
            pend_grow <= 1'b0;
            failure   <= 1'b0;
            success   <= 1'b0;
            sx        <= '0;
            sy        <= '0;
            sdir      <= '0;
            sfirst    <= 1'b0;
            slast     <= 1'b0;
            svalid    <= 1'b0;
        end else begin
            state     <= state_n;
            idx       <= idx_n;
            len       <= len_n;
            dirs      <= dirs_n;
            heading   <= heading_n;
            hx        <= hx_n;
            hy        <= hy_n;
            wx        <= wx_n;
            wy        <= wy_n;
            pending   <= pending_n;
            pend_grow <= pend_grow_n;
            failure   <= failure_n;
            success   <= success_n;
            sx        <= sx_n;
            sy        <= sy_n;
            sdir      <= sdir_n;
            sfirst    <= sfirst_n;
            slast     <= slast_n;
            svalid    <= svalid_n;
        end
    end

    assign snake_head_x    = hx;
    assign snake_head_y    = hy;
    assign bus.snake_x     = sx;
    assign bus.snake_y     = sy;
    assign bus.snake_dir   = sdir;
    assign bus.snake_first = sfirst;
    assign bus.snake_last  = slast;
    assign bus.snake_valid = svalid;
endmodule

// File: doc/snake_streamer.md
# snake_streamer

Owns the snake body state: head position, per-segment direction queue and length. Applies move/grow steps from game control and detects wall and self collisions. Continuously streams the body, head to tail, one segment per clock, as the `snake_*` segment stream consumed by the VGA renderer. It is the producer end of that stream; the renderer is the consumer.

## Interface
- `GAME_WIDTH`, default 18: playfield columns, valid x = 1..GAME_WIDTH.
- `GAME_HEIGHT`, default 13: playfield rows, valid y = 1..GAME_HEIGHT.
- `MAX_LEN`, default 32: maximum segment count, ≥ 3.
- `clk` (in, 1): clock.
- `rst` (in, 1): synchronous reset, active-high.
- `step` (in, 1): pulse requesting one move.
- `grow` (in, 1): sampled with `step`; length increases by 1 on that move.
- `dir_in` (in, 2): requested heading; 0 = up, 1 = down, 2 = left, 3 = right.
- `snake_head_x` (out, 5), `snake_head_y` (out, 4): current head tile.
- `snake_x` (out, 5), `snake_y` (out, 4): streamed segment tile.
- `snake_dir` (out, 2): direction from this segment toward the next (tail-ward) segment.
- `snake_first` (out, 1): segment is the head.
- `snake_last` (out, 1): segment is the tail.
- `snake_valid` (out, 1): stream fields are valid.
- `failure` (out, 1): sticky; wall hit or self collision.
- `success` (out, 1): sticky; length reached `MAX_LEN`.

## Operation
**State.**
- `hx`/`hy`: head tile.
- `heading`: last applied direction.
- `len`: current length, 2..MAX_LEN.
- `dirs[0..MAX_LEN-2]`: 2-bit direction queue; `dirs[k]` points from segment k to segment k+1.
- Opposite of direction d is `{d[1], ~d[0]}`.
- Delta: up y-1, down y+1, left x-1, right x+1.

**Reset values.**
- hx=3, hy=7, heading=3 (right), len=2, dirs[0]=2 (left).
- All stream outputs 0.
- `failure`=0, `success`=0.

**FSM.**
- WALK:
  - Emits segment `idx` (0..len-1) per cycle.
  - First segment is (hx,hy). Each later segment = previous segment + delta(dirs[idx-1]).
  - `snake_dir`=dirs[idx] for non-last segments; 0 when `snake_last`=1.
  - `snake_first`=(idx==0). `snake_last`=(idx==len-1).
  - After idx==len-1, go to GAP.
- GAP: one cycle, `snake_valid`=0. Applies a pending step if one exists, then goes to WALK with idx=0.

**Step rules.**
- `step` sets `pending`. `grow` ORs into `pend_grow`. Multiple steps before GAP coalesce into one.
- In GAP, when pending and neither `failure` nor `success` is set:
  - d = `dir_in`, except d = `heading` when `dir_in`==opposite(`heading`).
  - New head = head + delta(d), computed in 6-bit/5-bit signed arithmetic.
  - If the new head is outside 1..GAME_WIDTH / 1..GAME_HEIGHT: set `failure`; head, queue and len are unchanged.
  - Otherwise:
    - Head takes the new value and `heading`=d.
    - Queue shifts: `dirs[k+1]`=`dirs[k]`, then `dirs[0]`=opposite(d).
    - len = min(len + pend_grow, MAX_LEN).
    - Set `success` if the new len == MAX_LEN.
- `pending` and `pend_grow` clear in every GAP cycle.
- With `failure` or `success` set, steps are discarded and streaming continues unchanged.

**Self collision.**
- During WALK, any segment with idx ≥ 1 whose coordinates equal (hx,hy) sets `failure`.
- The flag is registered the cycle after that segment is emitted.

## Timing
- All outputs are registered.
- First `snake_valid`=1 appears on the first clock after `rst` deasserts.
- Pass period = len + 1 cycles: len valid cycles followed by 1 GAP cycle.
- A step seen in a WALK cycle is applied in the following GAP. The next pass shows the moved snake.
- A step asserted in the GAP cycle itself is applied in that same GAP.
- `snake_head_*` updates on the clock edge ending GAP, together with the first segment of the new pass.
- `rst` mid-pass aborts the pass. Outputs take reset values on the next edge.

## Configuration
- `SNAKE_WRAP_EN` defined: leaving the playfield wraps to the opposite edge (x 0→GAME_WIDTH, GAME_WIDTH+1→1; same rule for y). Walls never set `failure`; self collision still does.
- `SNAKE_WRAP_EN` undefined: wall exit sets `failure` as described above.

## Test plan
- Reset, release:
  - cycle 1: valid, (3,7), dir=2, first=1.
  - cycle 2: valid, (2,7), last=1.
  - cycle 3: valid=0.
  - Period is 3.
- `step` with dir_in=3 during WALK: next pass is head (4,7) dir 2, then tail (3,7). `snake_head_x`=4.
- `step` with dir_in=2 while heading right: reversal ignored, next head (5,7), heading stays 3.
- Three `step`+`grow` with dir_in=3: len=5, pass period 6, tail at (head_x−4, 7).
- Step right until head x=18, then step right again:
  - Without macro: `failure`=1, head stays (18,7), later steps ignored.
  - With `SNAKE_WRAP_EN`: head=(1,7), `failure`=0.
- len=5, head (10,7) heading right; steps down, left, up: head (9,7) equals segment 4, `failure`=1 during the following pass.
